// File: rtl/esn_interpreter.sv
// Echo state network readout: serial signed MAC over the reservoir vector with saturation.
// Optional INTERP_SQUARE_EN: output the squared accumulator instead of its sign extension.
module esn_interpreter #(
  parameter int unsigned reservoir_size = 4,
  parameter int unsigned data_width     = 3,
  parameter int unsigned weight_size    = 2,
  parameter int unsigned layer          = 1,
  parameter logic [reservoir_size*weight_size-1:0] WEIGHTS = 8'b01_11_10_01
) (
  input  logic                                              iClk,
  input  logic                                              iRst_n,
  input  logic                                              iEn,
  input  logic [reservoir_size*data_width-1:0]              iData,
  output logic [2*(data_width+weight_size+layer):0]         oValue,
  output logic                                              oIntRdy
);

  localparam int unsigned N  = reservoir_size;
  localparam int unsigned DW = data_width;
  localparam int unsigned WS = weight_size;
  localparam int unsigned A  = data_width + weight_size + layer;
  localparam int unsigned PW = DW + WS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned VW = 2 * A + 1;

  localparam logic [IW-1:0]       LAST_IDX = IW'(N - 1);
  localparam logic signed [A-1:0] ACC_MAX  = {1'b0, {(A-1){1'b1}}};
  localparam logic signed [A-1:0] ACC_MIN  = {1'b1, {(A-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                 state_q, state_d;
  logic [N*DW-1:0]        data_q, data_d;
  logic signed [A-1:0]    acc_q, acc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   sat_q, sat_d;
  logic [VW-1:0]          value_d;
  logic                   rdy_d;

  logic signed [WS-1:0]   w_sel;
  logic signed [DW-1:0]   x_sel;
  logic signed [PW-1:0]   prod;
  logic signed [A:0]      sum;
  logic [2*A-1:0]         result;

  // One-element multiply with a guard bit so overflow shows as sum[A] != sum[A-1]
  assign w_sel = $signed(WEIGHTS[int'(idx_q)*WS +: WS]);
  assign x_sel = $signed(data_q[int'(idx_q)*DW +: DW]);
  assign prod  = w_sel * x_sel;
  assign sum   = (A+1)'(acc_q) + (A+1)'(prod);

`ifdef INTERP_SQUARE_EN
  logic signed [2*A-1:0] sq;
  assign sq     = acc_q * acc_q;
  assign result = sq;
`else
  assign result = {{A{acc_q[A-1]}}, acc_q};
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    value_d = oValue;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iEn) begin
          data_d  = iData;
          acc_d   = '0;
          sat_d   = 1'b0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (sum[A] != sum[A-1]) begin
          acc_d = sum[A] ? ACC_MIN : ACC_MAX;
          sat_d = 1'b1;
        end else begin
          acc_d = sum[A-1:0];
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = OUT;
        end
      end
      OUT: begin
        value_d = {sat_q, result};
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      oValue  <= '0;
      oIntRdy <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      oValue  <= value_d;
      oIntRdy <= rdy_d;
    end
  end

endmodule

// File: tb/tb_esn_interpreter.sv
// Randomized self-checking bench for esn_interpreter: default weights and all -2 weights side by side.
module tb_esn_interpreter;

  localparam logic [7:0] W_DEF = 8'b01_11_10_01;
  localparam logic [7:0] W_NEG = 8'b10_10_10_10;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] data;
  logic [12:0] value_a, value_b;
  logic        rdy_a, rdy_b;

  int checks = 0;
  int errors = 0;

  esn_interpreter dut_a (
    .iClk(clk), .iRst_n(rst_n), .iEn(en), .iData(data),
    .oValue(value_a), .oIntRdy(rdy_a)
  );

  esn_interpreter #(.WEIGHTS(W_NEG)) dut_b (
    .iClk(clk), .iRst_n(rst_n), .iEn(en), .iData(data),
    .oValue(value_b), .oIntRdy(rdy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer weighted sum, clamped after every addition to 6-bit signed range
  function automatic logic [12:0] model(input logic [11:0] d, input logic [7:0] w);
    int acc = 0;
    int res;
    bit sat = 0;
    logic signed [2:0] xs;
    logic signed [1:0] ws;
    for (int i = 0; i < 4; i++) begin
      xs = d[i*3 +: 3];
      ws = w[i*2 +: 2];
      acc = acc + int'(xs) * int'(ws);
      if (acc > 31) begin acc = 31; sat = 1; end
      if (acc < -32) begin acc = -32; sat = 1; end
    end
`ifdef INTERP_SQUARE_EN
    res = acc * acc;
`else
    res = acc;
`endif
    return {sat, 12'(res)};
  endfunction

  task automatic run_one(input string tag, input logic [11:0] d, input bit scramble);
    int lat = 0;
    @(negedge clk);
    data = d;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    if (scramble) data = 12'($urandom);
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble) data = 12'($urandom);
      if (rdy_a) break;
    end
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_rdyb"}, 32'(rdy_b), 32'd1);
    check({tag, "_va"}, 32'(value_a), 32'(model(d, W_DEF)));
    check({tag, "_vb"}, 32'(value_b), 32'(model(d, W_NEG)));
    @(posedge clk);
    #1;
    check({tag, "_drop"}, 32'(rdy_a), 32'd0);
    check({tag, "_hold"}, 32'(value_a), 32'(model(d, W_DEF)));
  endtask

  initial begin
    int pulses;
    int last_cyc;
    logic [11:0] d;
    rst_n = 1'b0;
    en    = 1'b0;
    data  = '0;
    #1;
    check("reset_va", 32'(value_a), 32'd0);
    check("reset_rdy", 32'(rdy_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("basic", 12'b011_110_010_001, 1'b0);
    run_one("sat", 12'b100_100_100_100, 1'b0);
    run_one("neg", 12'b011_011_011_011, 1'b0);
    run_one("chg", 12'b011_110_010_001, 1'b1);
    for (int i = 0; i < 24; i++) begin
      d = 12'($urandom);
      run_one("rnd", d, 1'($urandom_range(0, 1)));
    end

    // Held-high start request: one result every six cycles
    @(negedge clk);
    data = 12'b011_110_010_001;
    en = 1'b1;
    pulses = 0;
    last_cyc = -1;
    for (int c = 1; c <= 31; c++) begin
      @(posedge clk);
      #1;
      if (rdy_a) begin
        if (last_cyc >= 0) check("held_gap", 32'(c - last_cyc), 32'd6);
        check("held_va", 32'(value_a), 32'(model(data, W_DEF)));
        last_cyc = c;
        pulses++;
      end
    end
    check("held_count", 32'(pulses >= 4), 32'd1);
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(posedge clk);

    // Reset during accumulation aborts with no strobe
    @(negedge clk);
    data = 12'b100_100_100_100;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_va", 32'(value_a), 32'd0);
    check("abort_vb", 32'(value_b), 32'd0);
    check("abort_rdy", 32'(rdy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (rdy_a || rdy_b) pulses++;
    end
    check("abort_nostrobe", 32'(pulses), 32'd0);
    run_one("recover", 12'b100_100_100_100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/esn_interpreter.md
Name: esn_interpreter

Overview:
- Readout stage of the integer echo state network; turns a packed reservoir state vector into one scalar output.
- Computes a signed weighted sum (sum of w_i * x_i) of the reservoir elements with fixed parameter weights, using one multiply-accumulate per clock.
- Presents the result with a one-cycle ready strobe to downstream logic.

Parameters:
- reservoir_size, 4, number of reservoir elements (N)
- data_width, 3, width of each signed two's-complement element x_i
- weight_size, 2, width of each signed two's-complement readout weight w_i
- layer, 1, extra accumulator guard bits; accumulator width A = data_width+weight_size+layer
- WEIGHTS, 8'b01_11_10_01, packed weights; w_i = WEIGHTS[i*weight_size +: weight_size]; default w3=1, w2=-1, w1=-2, w0=1

Ports:
- iClk  in  1  clock, rising edge
- iRst_n  in  1  reset, asynchronous, active-low
- iEn  in  1  start request, sampled only in IDLE
- iData  in  reservoir_size*data_width  packed state; x_i = iData[i*data_width +: data_width], signed
- oValue  out  2A+1  bit 2A = saturation flag; bits 2A-1:0 = result (see Optional Feature)
- oIntRdy  out  1  result-valid strobe, high for exactly one cycle

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, oValue=0, oIntRdy=0, accumulator=0, index=0, sat=0. Reset asserted mid-computation aborts it; no strobe is produced.
- FSM states are IDLE, ACC and OUT.
- IDLE: on an edge with iEn=1, capture iData into an internal register, clear the accumulator and sat, set index=0, go to ACC. With iEn=0, stay in IDLE.
- ACC: each edge adds sign-extended w_idx*x_idx (elements taken in order 0..N-1) to the accumulator and increments index. After the edge that adds element N-1, go to OUT.
- Accumulator is A bits signed. Every addition saturates to [-2^(A-1), 2^(A-1)-1]. Any clamp sets the sticky sat flag for the current computation.
- OUT: on the edge, load oValue[2A] = sat and oValue[2A-1:0] = the result, assert oIntRdy for that cycle, then return to IDLE.
- oValue holds its value until the next OUT edge.
- Latency: oIntRdy goes high after the (N+1)th rising edge following the capture edge (5 edges for N=4). It drops after one cycle.
- iEn and iData are ignored while in ACC or OUT; later changes to iData do not affect a computation in progress.
- With iEn held high, a new computation starts every N+2 cycles (6 for N=4).
- Result without the optional feature: accumulator sign-extended from A bits to 2A bits.

Optional Feature:
- Macro INTERP_SQUARE_EN.
- Defined: oValue[2A-1:0] = accumulator * accumulator (unsigned, fits 2A bits). The sat flag and all timing are unchanged.
- Undefined: oValue[2A-1:0] = sign-extended accumulator.

Test Plan:
- Defaults, iData=12'b011_110_010_001 (x3=3, x2=-2, x1=2, x0=1), iEn rises after reset. Result is 3+2-4+1=2: oIntRdy pulses 5 edges after capture, oValue=13'd2. With INTERP_SQUARE_EN: 13'd4.
- Same stimulus with iEn held high: oIntRdy pulses every 6 cycles, each time with oValue=13'd2.
- WEIGHTS=8'b10_10_10_10, iData=12'b100_100_100_100. The sum reaches 32 and clamps to 31: oValue=13'h101F (sat=1, result 31).
- WEIGHTS=8'b10_10_10_10, iData=12'b011_011_011_011. Sum is -24: oValue = {0, 12'hFE8} = 13'h0FE8, no saturation.
- Change iData during ACC: the result is still computed from the captured vector; a single oIntRdy pulse with the original result.
- Assert iRst_n=0 mid-ACC: oValue=0 and oIntRdy=0 immediately; no strobe after release until a new iEn.
